// File: rtl/rle_pkg.sv
// Shared RLE definitions: state encoding, default widths and the run-pair
// layout used by both the encoder and decoder sides.
package rle_pkg;

   localparam int DATA_W_DEF  = 1;
   localparam int COUNT_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // Count field holds run length minus one.
   typedef struct packed {
      logic                   last;
      logic [COUNT_W_DEF-1:0] count;
      logic [DATA_W_DEF-1:0]  value;
   } rle_pair_t;

   localparam int PAIR_W = $bits(rle_pair_t);

endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of
// wrapping.
module rle_run_counter
   import rle_pkg::*;
#(
   parameter int W = COUNT_W_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (value, length-1, last) run pairs into a
// symbol stream with zero-bubble hand-over between consecutive runs.
module rle_decoder
   import rle_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_value,
   input  logic [COUNT_W-1:0] in_count,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic               busy
);

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_value;
   logic                r_last;
   logic [COUNT_W-1:0]  w_remain;
   logic                w_zero;
   logic                w_load;
   logic                w_dec;
   logic                w_in_hs;
   logic                w_out_hs;
   logic                w_emit;

   assign w_emit   = (r_state == EMIT);
   assign w_out_hs = w_emit & out_ready;
   assign w_in_hs  = in_valid & in_ready;

   // Accept a new run while idle, or as the final symbol leaves.
   assign in_ready = reset &
                     (~w_emit | (w_zero & out_ready));

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_dec  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_in_hs) begin
               w_load = 1'b1;
               w_next = EMIT;
            end
         end
         EMIT: begin
            if (w_out_hs && !w_zero) begin
               w_dec = 1'b1;
            end else if (w_out_hs && w_in_hs) begin
               w_load = 1'b1;
            end else if (w_out_hs) begin
               w_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_value <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_value <= in_value;
            r_last  <= in_last;
         end
      end
   end

   rle_run_counter #(
      .W (COUNT_W)
   ) u_remain (
      .clock      (clock),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (in_count),
      .i_dec      (w_dec),
      .o_count    (w_remain),
      .o_zero     (w_zero)
   );

   assign out_valid = w_emit;
   assign out_data  = w_emit ? r_value : '0;
   assign out_last  = w_emit & r_last & w_zero;
   assign busy      = w_emit;

endmodule
